// File: rtl/reg_file_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_if
// Description : Write-back writer / decode reader bundle for reg_file_wb.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_wb_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    localparam int ADDR_W = $clog2(NREGS);

    logic              RegWriteW;
    logic [ADDR_W-1:0] RdW;
    logic [WIDTH-1:0]  ResultW;
    logic [ADDR_W-1:0] A1D;
    logic [ADDR_W-1:0] A2D;
    logic [WIDTH-1:0]  RD1D;
    logic [WIDTH-1:0]  RD2D;
    logic              InitBusy;

    modport master (
        output RegWriteW, RdW, ResultW, A1D, A2D,
        input  RD1D, RD2D, InitBusy
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, A1D, A2D,
        output RD1D, RD2D, InitBusy
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb
// Description : Integer register file, WB-stage write, two bypassed ID reads,
//               with a sequencer that zeroes x1..x(NREGS-1) after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    reg_file_wb_if.slave   bus
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [WIDTH-1:0]  regs_q [1:NREGS-1];
    logic              w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_ptr_q <= ADDR_W'(1);
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // The pointer parks on the last index; the state change ends the sweep.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == S_INIT) begin
            if (init_ptr_q == LAST_IDX) begin
                state_d = S_RUN;
            end else begin
                init_ptr_d = init_ptr_q + ADDR_W'(1);
            end
        end
    end

    // Storage carries no reset; writes arriving while clearing are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_INIT) begin
                regs_q[init_ptr_q] <= '0;
            end else if (bus.RegWriteW && (bus.RdW != '0)) begin
                regs_q[bus.RdW] <= bus.ResultW;
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [WIDTH-1:0]  wr_data
    );
        logic [WIDTH-1:0] data;
        if (addr == '0) begin
            data = '0;
        end else if (wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end else begin
            data = regs_q[addr];
        end
        return data;
    endfunction

    assign w_busy       = reset | (state_q != S_RUN);
    assign bus.InitBusy = w_busy;

    assign bus.RD1D = w_busy ? '0 : read_port(bus.A1D, bus.RegWriteW, bus.RdW, bus.ResultW);
    assign bus.RD2D = w_busy ? '0 : read_port(bus.A2D, bus.RegWriteW, bus.RdW, bus.ResultW);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb
// Description : Directed self-checking bench for reg_file_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    reg_file_wb_if #(.WIDTH(32), .NREGS(32)) bus ();

    reg_file_wb #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.RegWriteW = en;
        bus.RdW       = rd;
        bus.ResultW   = data;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.A1D = a1;
        bus.A2D = a2;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd4);

        // Reset cycle: busy and gated reads
        chk("busy_in_reset", {31'b0, bus.InitBusy}, 32'd1);
        chk("rd1_in_reset", bus.RD1D, 32'h0);
        tick();
        reset = 1'b0;
        #1;

        // Test 1: 31 busy cycles, then idle
        for (int i = 0; i < 31; i++) begin
            chk($sformatf("busy_init_%0d", i), {31'b0, bus.InitBusy}, 32'd1);
            tick();
        end
        chk("busy_done", {31'b0, bus.InitBusy}, 32'd0);
        for (int a = 1; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            chk($sformatf("zero_x%0d", a), bus.RD1D, 32'h0);
        end

        // Test 2: write then storage read, then same-cycle bypass
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd0);
        chk("bypass_x5_rd1", bus.RD1D, 32'hDEADBEEF);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        chk("stored_x5", bus.RD1D, 32'hDEADBEEF);
        set_wr(1'b1, 5'd5, 32'h12345678);
        set_rd(5'd5, 5'd5);
        chk("bypass_x5_rd2", bus.RD2D, 32'h12345678);
        chk("bypass_x5_rd1b", bus.RD1D, 32'h12345678);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        chk("stored_x5_new", bus.RD1D, 32'h12345678);

        // Test 3: x0 writes discarded
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0);
        chk("x0_rd1_same", bus.RD1D, 32'h0);
        chk("x0_rd2_same", bus.RD2D, 32'h0);
        tick();
        #1;
        chk("x0_rd1_next", bus.RD1D, 32'h0);
        chk("x0_rd2_next", bus.RD2D, 32'h0);
        set_wr(1'b0, 5'd0, 32'h0);

        // Test 4: both ports on x7 via bypass, then storage
        set_wr(1'b1, 5'd7, 32'hA5A5A5A5);
        set_rd(5'd7, 5'd7);
        chk("x7_bp_rd1", bus.RD1D, 32'hA5A5A5A5);
        chk("x7_bp_rd2", bus.RD2D, 32'hA5A5A5A5);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd7, 5'd7);
        chk("x7_st_rd1", bus.RD1D, 32'hA5A5A5A5);
        chk("x7_st_rd2", bus.RD2D, 32'hA5A5A5A5);

        // Ports resolve independently: one bypassed, one from storage
        set_wr(1'b1, 5'd7, 32'h00000001);
        set_rd(5'd5, 5'd7);
        chk("mix_rd1_store", bus.RD1D, 32'h12345678);
        chk("mix_rd2_bypass", bus.RD2D, 32'h00000001);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd7, 5'd0);
        chk("x7_overwritten", bus.RD1D, 32'h00000001);

        // Test 5: x9 written, reset, reset again at INIT cycle 10
        set_wr(1'b1, 5'd9, 32'h00000055);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd9, 5'd0);
        chk("x9_stored", bus.RD1D, 32'h00000055);
        reset = 1'b1;
        #1;
        chk("busy_run_reset", {31'b0, bus.InitBusy}, 32'd1);
        chk("rd_gated_reset", bus.RD1D, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("busy_first_%0d", i), {31'b0, bus.InitBusy}, 32'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Test 6: writes during INIT dropped, reads return 0
        set_wr(1'b1, 5'd31, 32'h00000099);
        set_rd(5'd31, 5'd9);
        for (int i = 0; i < 31; i++) begin
            chk($sformatf("busy_re_%0d", i), {31'b0, bus.InitBusy}, 32'd1);
            chk($sformatf("init_rd1_%0d", i), bus.RD1D, 32'h0);
            chk($sformatf("init_rd2_%0d", i), bus.RD2D, 32'h0);
            tick();
        end
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd31, 5'd9);
        chk("busy_re_done", {31'b0, bus.InitBusy}, 32'd0);
        chk("x31_dropped", bus.RD1D, 32'h0);
        chk("x9_cleared", bus.RD2D, 32'h0);
        set_rd(5'd5, 5'd7);
        chk("x5_cleared", bus.RD1D, 32'h0);
        chk("x7_cleared", bus.RD2D, 32'h0);

        // Storage works again after re-init
        set_wr(1'b1, 5'd31, 32'hCAFEF00D);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd31, 5'd30);
        chk("x31_after", bus.RD1D, 32'hCAFEF00D);
        chk("x30_after", bus.RD2D, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
